// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clocks per serial bit; integer divide, so the line rate rounds up slightly.
  function automatic int bit_ticks(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: tick marks the final clk of every TICKS-clk bit period.
// tickNext marks the clk just before it, so users can register edge-aligned pulses.
module baud_tick_gen #(
  parameter int TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tickNext
);

  localparam int CNT_W = $clog2(TICKS);

  if (TICKS < 2) begin : gBadTicks
    $error("baud_tick_gen: TICKS must be >= 2, got %0d", TICKS);
  end

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick     = (count == CNT_W'(TICKS - 1));
  assign tickNext = (count == CNT_W'(TICKS - 2));

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised async serial transmitter: start, DATA_BITS LSB-first, optional
// parity, 1-2 stop bits, one word per ready/valid handshake, gapless back-to-back.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD_RATE   = 19200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 s_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BIT_TICKS = bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam int STOP_W    = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  if (BIT_TICKS < 2) begin : gBadBaud
    $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be >= 2, got %0d", BIT_TICKS);
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_tx_frame: DATA_BITS must be 5..9, got %0d", DATA_BITS);
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
      PARITY_MODE != PARITY_ODD) begin : gBadParity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2, got %0d", PARITY_MODE);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2, got %0d", STOP_BITS);
  end

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shReg;
  logic                 parBit;
  logic [BIT_W-1:0]     bitCnt;
  logic [STOP_W-1:0]    stopCnt;
  logic                 txOut;
  logic                 busyQ;
  logic                 frameDoneQ;

  logic tick;
  logic tickNext;
  logic accept;
  logic lastBit;
  logic lastStop;
  logic frameEnd;
  logic nextParity;

  assign lastBit    = (bitCnt == BIT_W'(DATA_BITS - 1));
  assign lastStop   = (stopCnt == STOP_W'(STOP_BITS - 1));
  assign frameEnd   = (state == STOP) && lastStop && tick;
  assign s_ready    = !rst && ((state == IDLE) || frameEnd);
  assign accept     = s_valid && s_ready;
  assign nextParity = (PARITY_MODE == PARITY_EVEN) ? ^s_data : ~^s_data;

  // Restarting the bit period on accept aligns the start bit to the handshake.
  baud_tick_gen #(
    .TICKS(BIT_TICKS)
  ) uBaud (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .tick     (tick),
    .tickNext (tickNext)
  );

  // NOTE: the shift register is cleared on reset as well; it is a handful of
  // flops, not a RAM, so a known value costs nothing and keeps sim X-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shReg      <= '0;
      parBit     <= 1'b0;
      bitCnt     <= '0;
      stopCnt    <= '0;
      txOut      <= 1'b1;
      busyQ      <= 1'b0;
      frameDoneQ <= 1'b0;
    end else begin
      // Registered pulse lands on the final clk of the last stop bit.
      frameDoneQ <= (state == STOP) && lastStop && tickNext;

      unique case (state)
        IDLE: begin
          if (accept) begin
            shReg  <= s_data;
            parBit <= nextParity;
            txOut  <= 1'b0;
            busyQ  <= 1'b1;
            state  <= START;
          end
        end

        START: begin
          if (tick) begin
            bitCnt <= '0;
            txOut  <= shReg[0];
            state  <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            if (lastBit) begin
              if (PARITY_MODE != PARITY_NONE) begin
                txOut <= parBit;
                state <= PARITY;
              end else begin
                stopCnt <= '0;
                txOut   <= 1'b1;
                state   <= STOP;
              end
            end else begin
              bitCnt <= bitCnt + BIT_W'(1);
              shReg  <= shReg >> 1;
              txOut  <= shReg[1];
            end
          end
        end

        PARITY: begin
          if (tick) begin
            stopCnt <= '0;
            txOut   <= 1'b1;
            state   <= STOP;
          end
        end

        STOP: begin
          if (tick) begin
            if (lastStop) begin
              // A word accepted here starts immediately; busy stays high.
              if (accept) begin
                shReg  <= s_data;
                parBit <= nextParity;
                txOut  <= 1'b0;
                state  <= START;
              end else begin
                busyQ <= 1'b0;
                state <= IDLE;
              end
            end else begin
              stopCnt <= stopCnt + STOP_W'(1);
            end
          end
        end

        default: begin
          txOut <= 1'b1;
          busyQ <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tx_out     = txOut;
  assign busy       = busyQ;
  assign frame_done = frameDoneQ;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three parameterisations sharing one clock,
// each frame compared clk-by-clk against hand-built expected bit sequences.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] dataIn;
  int         sel;

  logic validA, readyA, txA, busyA, doneA;
  logic validB, readyB, txB, busyB, doneB;
  logic validC, readyC, txC, busyC, doneC;
  logic txObs, busyObs, doneObs, readyObs;

  int total;
  int bad;

  always #5 clk = ~clk;

  assign validA = valid && (sel == 0);
  assign validB = valid && (sel == 1);
  assign validC = valid && (sel == 2);

  // 8 data bits, odd parity, 1 stop
  uart_tx_frame #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .s_valid(validA), .s_data(dataIn),
    .s_ready(readyA), .tx_out(txA), .busy(busyA), .frame_done(doneA));

  // 7 data bits, even parity, 2 stop
  uart_tx_frame #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7),
                  .PARITY_MODE(1), .STOP_BITS(2)) dutB (
    .clk(clk), .rst(rst), .s_valid(validB), .s_data(dataIn[6:0]),
    .s_ready(readyB), .tx_out(txB), .busy(busyB), .frame_done(doneB));

  // 8 data bits, no parity, 1 stop
  uart_tx_frame #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) dutC (
    .clk(clk), .rst(rst), .s_valid(validC), .s_data(dataIn),
    .s_ready(readyC), .tx_out(txC), .busy(busyC), .frame_done(doneC));

  always_comb begin
    txObs = 1'b0; busyObs = 1'b0; doneObs = 1'b0; readyObs = 1'b0;
    case (sel)
      0: begin txObs = txA; busyObs = busyA; doneObs = doneA; readyObs = readyA; end
      1: begin txObs = txB; busyObs = busyB; doneObs = doneB; readyObs = readyB; end
      2: begin txObs = txC; busyObs = busyC; doneObs = doneC; readyObs = readyC; end
      default: ;
    endcase
  end

  // Sends one word (or two held back-to-back) on the selected instance and
  // compares {tx, busy, frame_done, s_ready} every clk until the line idles.
  // bits holds the expected line value per bit slot, slot 0 = first start bit.
  task automatic runFrames(input string name, input int which,
                           input logic [7:0] d1, input logic [7:0] d2,
                           input bit two, input bit noise,
                           input logic [31:0] bits, input int frameBits);
    int frameClks;
    int lastK;
    int waitCnt;
    logic expTx, expBusy, expDone;
    logic [3:0] obs, exp;
    sel = which;
    #1;
    waitCnt = 0;
    while (readyObs !== 1'b1 && waitCnt < 300) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    total++;
    if (readyObs !== 1'b1) begin
      bad++;
      $display("FAIL %s ready-before-send got=%b want=1", name, readyObs);
    end
    valid  = 1'b1;
    dataIn = d1;
    @(posedge clk); #1;
    if (two) begin
      dataIn = d2;
    end else begin
      valid  = 1'b0;
      dataIn = ~d1;
    end
    frameClks = frameBits * 10;
    lastK     = two ? 2 * frameClks : frameClks;
    for (int k = 0; k <= lastK + 2; k++) begin
      expTx   = (k < lastK) ? bits[k / 10] : 1'b1;
      expBusy = (k < lastK);
      expDone = (k < lastK) && ((k % frameClks) == frameClks - 1);
      exp = {expTx, expBusy, expDone, expDone || (k >= lastK)};
      obs = {txObs, busyObs, doneObs, readyObs};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s clk=%0d tx/busy/done/ready got=%b want=%b", name, k, obs, exp);
      end
      if (noise && k == 20) begin valid = 1'b1; dataIn = 8'h00; end
      if (noise && k == 30) valid = 1'b0;
      @(posedge clk); #1;
      if (two && k == frameClks - 1) begin
        valid  = 1'b0;
        dataIn = ~d2;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        sel = s; #1;
        obs = {txObs, busyObs, doneObs, readyObs};
        total++;
        if (obs !== 4'b1000) begin
          bad++;
          $display("FAIL reset_held dut=%0d clk=%0d got=%b want=1000", s, c, obs);
        end
      end
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      obs = {txObs, busyObs, doneObs, readyObs};
      total++;
      if (obs !== 4'b1001) begin
        bad++;
        $display("FAIL reset_release dut=%0d got=%b want=1001", s, obs);
      end
    end
    sel = 0;
  endtask

  task automatic test_8o1;
    runFrames("8o1_0x55", 0, 8'h55, 8'h00, 1'b0, 1'b0,
              {21'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
  endtask

  task automatic test_7e2;
    runFrames("7e2_0x41", 1, 8'h41, 8'h00, 1'b0, 1'b0,
              {21'b0, 1'b1, 1'b1, 1'b0, 7'h41, 1'b0}, 11);
  endtask

  task automatic test_no_parity;
    runFrames("8n1_0xFF", 2, 8'hFF, 8'h00, 1'b0, 1'b1,
              {22'b0, 1'b1, 8'hFF, 1'b0}, 10);
  endtask

  task automatic test_back_to_back;
    runFrames("b2b_A5_3C", 0, 8'hA5, 8'h3C, 1'b1, 1'b0,
              {10'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] obs;
    sel = 0; #1;
    valid  = 1'b1;
    dataIn = 8'h55;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 0; k < 34; k++) begin
      @(posedge clk); #1;
    end
    // clk 34 of 0x55: slot 3 = data bit 2 = 1
    total++;
    if ({txObs, busyObs} !== 2'b11) begin
      bad++;
      $display("FAIL midreset_pre tx/busy got=%b want=11", {txObs, busyObs});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    obs = {txObs, busyObs, doneObs, readyObs};
    total++;
    if (obs !== 4'b1000) begin
      bad++;
      $display("FAIL midreset_abort got=%b want=1000", obs);
    end
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      obs = {txObs, busyObs, doneObs, readyObs};
      total++;
      if (obs !== 4'b1001) begin
        bad++;
        $display("FAIL midreset_idle clk=%0d got=%b want=1001", k, obs);
      end
    end
    runFrames("midreset_resend", 0, 8'h55, 8'h00, 1'b0, 1'b0,
              {21'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    valid  = 1'b0;
    dataIn = 8'h00;
    sel    = 0;
    test_reset;
    test_8o1;
    test_7e2;
    test_no_parity;
    test_back_to_back;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
